// File: rtl/bram_seq_ctrl_if.sv
// Bus bundle between bram_seq_ctrl and its surroundings: playback control,
// write requests from button/switch logic, the BRAM port and the display output.
//   slave  : the controller (drives wr_ack, mem_*, out_*, busy)
//   master : upstream logic plus BRAM (drives start/stop, wr_*, mem_r_data)
interface bram_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4
);
  logic              start;
  logic              stop;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;

  modport slave (
    input  start, stop, wr_req, wr_addr, wr_data, mem_r_data,
    output wr_ack, mem_we, mem_addr, mem_w_data, out_data, out_valid, out_addr, busy
  );

  modport master (
    output start, stop, wr_req, wr_addr, wr_data, mem_r_data,
    input  wr_ack, mem_we, mem_addr, mem_w_data, out_data, out_valid, out_addr, busy
  );
endinterface

// File: rtl/bram_seq_ctrl.sv
// Sequential playback controller for a synchronous read-first BRAM. Plays
// addresses 0..LAST_ADDR in a loop, one word every TICK_DIV cycles, with a
// one-cycle out_valid strobe; single-word writes are slotted in between reads.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bram_seq_ctrl_if.slave
//          start/stop pulses, wr_req/wr_addr/wr_data -> wr_ack handshake,
//          mem_we/mem_addr/mem_w_data/mem_r_data BRAM port,
//          out_data/out_addr/out_valid playback output, busy status.
// TICK_DIV must be >= 3 (READ + CAPTURE + at least one WAIT cycle).
module bram_seq_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned LAST_ADDR = 31
) (
  input logic            clk,
  input logic            rst,
  bram_seq_ctrl_if.slave bus
);

  localparam int unsigned       CntW    = $clog2(TICK_DIV);
  localparam logic [CntW-1:0]   CntLast = CntW'(TICK_DIV - 3);
  localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StWait, StWrite} state_e;

  state_e            state_q;
  state_e            ret_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_w_data_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              wr_ack_q;
  logic              busy_q;

  // No new write is taken while the previous one is being acknowledged.
  logic              wr_take;
  logic [ADDR_W-1:0] ptr_next;

  assign wr_take  = bus.wr_req & ~wr_ack_q;
  assign ptr_next = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_we_q    <= 1'b0;

      case (state_q)
        StIdle: begin
          if (wr_take) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= bus.wr_addr;
            mem_w_data_q <= bus.wr_data;
            ret_q        <= StIdle;
            state_q      <= StWrite;
            busy_q       <= 1'b1;
          end else if (bus.start && !bus.stop) begin
            ptr_q      <= '0;
            mem_addr_q <= '0;
            state_q    <= StRead;
            busy_q     <= 1'b1;
          end
        end

        StRead: begin
          if (bus.stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StCapture;
          end
        end

        StCapture: begin
          // A stop here drops the word the BRAM has just returned.
          if (bus.stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            out_data_q  <= bus.mem_r_data;
            out_addr_q  <= ptr_q;
            out_valid_q <= 1'b1;
            ptr_q       <= ptr_next;
            cnt_q       <= '0;
            state_q     <= StWait;
          end
        end

        StWait: begin
          if (bus.stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (wr_take) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= bus.wr_addr;
            mem_w_data_q <= bus.wr_data;
            state_q      <= StWrite;
            // The accepting WAIT cycle still consumes its tick, so every write
            // stretches the period by exactly the one WRITE cycle. On terminal
            // count the deferred tick fires straight after the write.
            if (cnt_q == CntLast) begin
              ret_q <= StRead;
            end else begin
              ret_q <= StWait;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q == CntLast) begin
            mem_addr_q <= ptr_q;
            state_q    <= StRead;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StWrite: begin
          wr_ack_q <= 1'b1;
          if (bus.stop || ret_q == StIdle) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ret_q;
            if (ret_q == StRead) begin
              mem_addr_q <= ptr_q;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Bench for bram_seq_ctrl with TICK_DIV = 4 and a 32x4 read-first BRAM model
// preloaded with mem[i] = i mod 16. A timeline model predicts every output each
// cycle; directed steps add literal checks on the key cases.
module tb_bram_seq_ctrl;

  localparam int Tick = 4;
  localparam int Last = 31;

  logic clk;
  logic rst;

  bram_seq_ctrl_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  bram_seq_ctrl #(
    .ADDR_W   (5),
    .DATA_W   (4),
    .TICK_DIV (Tick),
    .LAST_ADDR(Last)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: synchronous, read-first.
  logic [3:0] bram [32];
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_w_data;
    bus.mem_r_data <= bram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // s_edge is the clock edge after which the next strobe is visible; acc is
  // the edge at which the last write was accepted.
  logic [3:0] mem_m [32];
  int  cyc      = 0;
  int  acc      = -10;
  int  s_edge   = 0;
  int  m_ptr    = 0;
  bit  playing  = 0;
  bit  accepted = 0;
  logic       e_valid = 0, e_busy = 0, e_we = 0, e_ack = 0;
  logic [3:0] e_data = 0, e_wdata = 0;
  logic [4:0] e_addr = 0, e_maddr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      playing = 0; m_ptr = 0; acc = cyc - 10; s_edge = 0;
      e_valid = 0; e_busy = 0; e_we = 0; e_ack = 0;
      e_data = 0; e_addr = 0; e_maddr = 0; e_wdata = 0;
    end else begin
      cyc++;
      e_valid  = 0;
      e_we     = 0;
      e_ack    = (cyc == acc + 1);
      accepted = 0;
      // Writes wait while a read is in flight, during a write and its ack.
      if (bus.wr_req && cyc != acc + 1 && cyc != acc + 2 &&
          !(playing && (bus.stop || cyc == s_edge - 1 || cyc == s_edge))) begin
        accepted = 1;
        acc      = cyc;
        mem_m[bus.wr_addr] = bus.wr_data;
        e_we    = 1;
        e_maddr = bus.wr_addr;
        e_wdata = bus.wr_data;
        if (playing) s_edge++;
      end
      if (bus.stop && playing) begin
        playing = 0;
      end else if (bus.start && !bus.stop && !playing && !accepted && cyc != acc + 1) begin
        playing = 1;
        m_ptr   = 0;
        s_edge  = cyc + 2;
      end
      if (playing && cyc == s_edge) begin
        e_valid = 1;
        e_data  = mem_m[m_ptr];
        e_addr  = 5'(m_ptr);
        m_ptr   = (m_ptr == Last) ? 0 : m_ptr + 1;
        s_edge += Tick;
      end
      e_busy = playing || accepted;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", bus.out_valid, e_valid);
      check("out_data",  bus.out_data,  e_data);
      check("out_addr",  bus.out_addr,  e_addr);
      check("busy",      bus.busy,      e_busy);
      check("mem_we",    bus.mem_we,    e_we);
      check("wr_ack",    bus.wr_ack,    e_ack);
      if (e_we) begin
        check("mem_addr",   bus.mem_addr,   e_maddr);
        check("mem_w_data", bus.mem_w_data, e_wdata);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_strobe(output int iv);
    iv = 0;
    do begin
      @(negedge clk);
      iv++;
    end while (!bus.out_valid && iv < 20);
    if (!bus.out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: got no out_valid, expected one within 20 cycles");
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] d);
    int k;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wr_ack && k < 20);
    if (!bus.wr_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_ack_timeout: got no wr_ack, expected one within 20 cycles");
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic check_strobe(input string name, input int iv, input int exp_iv,
                              input logic [4:0] a, input logic [3:0] d);
    check({name, "_interval"}, iv, exp_iv);
    check({name, "_addr"}, bus.out_addr, a);
    check({name, "_data"}, bus.out_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected one before 200000");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int iv;
    for (int i = 0; i < 32; i++) begin
      bram[i]  = 4'(i % 16);
      mem_m[i] = 4'(i % 16);
    end
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_busy",      bus.busy,      0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // Write in IDLE: addr 5 <= 0xA.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 4'hA;
    @(negedge clk);
    check("idle_wr_we",   bus.mem_we,     1);
    check("idle_wr_addr", bus.mem_addr,   5);
    check("idle_wr_data", bus.mem_w_data, 4'hA);
    check("idle_wr_busy", bus.busy,       1);
    @(negedge clk);
    check("idle_wr_ack",    bus.wr_ack, 1);
    check("idle_wr_we_off", bus.mem_we, 0);
    bus.wr_req = 1'b0;

    // Start: first strobe two edges after the start sample.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    @(negedge clk);
    check("start_no_valid", bus.out_valid, 0);
    @(negedge clk);
    check_strobe("first", 2, 2, 0, 0);
    check("first_valid", bus.out_valid, 1);

    for (int k = 1; k <= 5; k++) begin
      wait_strobe(iv);
      check_strobe("play", iv, 4, 5'(k), (k == 5) ? 4'hA : 4'(k));
    end

    // Write on the WAIT terminal-count cycle, to the address about to be read.
    @(negedge clk) begin
      bus.wr_req = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 4'hC;
    end
    @(negedge clk);
    check("tc_wr_we", bus.mem_we, 1);
    @(negedge clk);
    check("tc_wr_ack", bus.wr_ack, 1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("tc_no_valid", bus.out_valid, 0);
    @(negedge clk);
    check("tc_valid", bus.out_valid, 1);
    check_strobe("tc_strobe", 5, 5, 6, 4'hC);
    wait_strobe(iv);
    check_strobe("after_tc", iv, 4, 7, 7);

    // Run through the wrap point.
    for (int k = 8; k <= 31; k++) begin
      wait_strobe(iv);
      if (k == 31) check_strobe("addr31", iv, 4, 31, 4'hF);
    end
    wait_strobe(iv);
    check_strobe("wrap", iv, 4, 0, 0);

    // Write in a non-terminal WAIT cycle: the period grows to 5 once.
    do_write(5'd9, 4'h1);
    wait_strobe(iv);
    check_strobe("mid_wait_wr", iv, 3, 1, 1);

    // Stop during CAPTURE of address 2.
    repeat (3) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
    check("stop_valid", bus.out_valid, 0);
    check("stop_busy",  bus.busy,      0);
    check("stop_data",  bus.out_data,  1);
    check("stop_addr",  bus.out_addr,  1);

    // start and stop together: stays idle.
    @(negedge clk) begin bus.start = 1'b1; bus.stop = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    check("start_stop_busy", bus.busy, 0);
    @(negedge clk);
    check("start_stop_busy2", bus.busy, 0);

    // Play again, then reset asynchronously mid-WAIT.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_strobe(iv);
    check_strobe("replay0", iv, 2, 0, 0);
    wait_strobe(iv);
    check_strobe("replay1", iv, 4, 1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data",  bus.out_data,  0);
    check("arst_addr",  bus.out_addr,  0);
    check("arst_busy",  bus.busy,      0);
    check("arst_valid", bus.out_valid, 0);
    @(negedge clk) rst = 1'b0;

    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_strobe(iv);
    check_strobe("post_rst0", iv, 2, 0, 0);
    wait_strobe(iv);
    check_strobe("post_rst1", iv, 4, 1, 1);

    @(negedge clk) bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_seq_ctrl.md
Name: bram_seq_ctrl

Overview:
Controller that drives the port of the 32x4 synchronous read-first block RAM (clk, we, addr[4:0], w_data[3:0], r_data[3:0]). It plays the memory back in sequence, one entry every TICK_DIV cycles, and presents each word with a one-cycle valid strobe to display and LED logic. It also accepts single-word write requests from button and switch logic, interleaved with playback. One instance sits directly upstream of each BRAM instance.

Parameters:
ADDR_W, 5, BRAM address width (depth = 2^ADDR_W)
DATA_W, 4, BRAM word width
TICK_DIV, 50000000, clock cycles between successive playback outputs; must be >= 3
LAST_ADDR, 31, highest address played before the pointer wraps to 0

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse: begin playback at address 0
stop  in  1  single-cycle pulse: end playback and return to IDLE
wr_req  in  1  write request; held high until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse, the cycle after the write is issued
mem_we  out  1  to BRAM we
mem_addr  out  ADDR_W  to BRAM addr
mem_w_data  out  DATA_W  to BRAM w_data
mem_r_data  in  DATA_W  from BRAM r_data (valid 1 cycle after addr)
out_data  out  DATA_W  last word played
out_valid  out  1  one-cycle strobe when out_data updates
out_addr  out  ADDR_W  address that out_data came from
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: state IDLE; ptr, tick counter and all outputs = 0.
- States: IDLE, READ, CAPTURE, WAIT, WRITE. All outputs are registered.
- IDLE:
  - wr_req -> WRITE; the return state is IDLE.
  - else start -> READ with ptr = 0.
- READ (1 cycle): mem_addr = ptr, mem_we = 0. The BRAM registers the read at the end of this cycle. Next state is CAPTURE.
- CAPTURE (1 cycle): mem_r_data holds mem[ptr]. At the end of the cycle:
  - out_data <= mem_r_data, out_addr <= ptr, out_valid <= 1 for exactly one cycle.
  - ptr <= ptr + 1, or 0 if ptr == LAST_ADDR.
  - Next state is WAIT with the counter cleared.
- WAIT:
  - The counter increments each cycle.
  - When the counter reaches TICK_DIV-3 -> READ.
  - With no writes, consecutive out_valid strobes are exactly TICK_DIV cycles apart.
- WRITE (1 cycle):
  - mem_we = 1, mem_addr = wr_addr, mem_w_data = wr_data.
  - Next cycle wr_ack = 1; the block returns to the saved state (IDLE or WAIT) with the WAIT counter unchanged.
  - Each accepted write lengthens the current playback period by 1 cycle.
- Write acceptance:
  - Writes are accepted only in IDLE or WAIT.
  - A request during READ or CAPTURE waits; wr_req stays high.
  - In WAIT, wr_req takes priority over the terminal-count transition; the tick is deferred, not lost.
  - The bench must drop wr_req on the cycle wr_ack is seen; the block accepts no new write in the wr_ack cycle.
- Read-during-write: a write to the address about to be read is seen by that read (the write completes first).
- mem_we is high only in WRITE. mem_addr and mem_w_data hold their last values elsewhere.
- stop:
  - From READ, CAPTURE or WAIT -> IDLE next cycle.
  - An in-flight read is discarded: no out_valid.
  - out_data and out_addr keep their last values.
  - stop during WRITE: the write completes and wr_ack is issued, then IDLE.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
- Reset, then start with TICK_DIV=4 and the memory preloaded mem[i]=i mod 16 -> out_valid every 4 cycles, out_data 0,1,2,…; first strobe 2 cycles after start; busy=1.
- Play past address 31 -> after out_addr=31 (data 0xF), the next strobe is out_addr=0, data 0x0.
- In IDLE, wr_req with addr=5, data=0xA -> mem_we=1 for one cycle with mem_addr=5, wr_ack next cycle; subsequent playback shows 0xA at address 5.
- wr_req asserted on the WAIT terminal-count cycle -> WRITE first, READ next; strobe interval becomes 5 cycles once, then 4.
- stop asserted during CAPTURE -> no out_valid, IDLE next cycle, out_data unchanged; start and stop together -> remains IDLE.
- Assert rst mid-WAIT -> all outputs 0 immediately, without a clock edge; after release, start again begins at address 0.
